// File: rtl/psum_drain_collector_if.sv
// Handshake bundle between the PE grid top row, the drain collector and the
// output buffer. The collector plugs in through the slave modport; the
// environment (grid controller plus output buffer) uses the master modport.
interface psum_drain_collector_if #(
    parameter int NUM_COLS     = 14,
    parameter int PSUM_WIDTH   = 32,
    parameter int COL_ID_WIDTH = 4
);
    // Grid-to-collector partial-sum vector
    logic                    psum_valid;
    logic                    psum_ready;
    logic [PSUM_WIDTH-1:0]   psum_in [0:NUM_COLS-1];

    // Collector-to-buffer result stream
    logic                    out_valid;
    logic                    out_ready;
    logic [PSUM_WIDTH-1:0]   out_data;
    logic [COL_ID_WIDTH-1:0] out_col;
    logic                    out_last;

    modport master (
        output psum_valid,
        output psum_in,
        input  psum_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_col,
        input  out_last
    );

    modport slave (
        input  psum_valid,
        input  psum_in,
        output psum_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_col,
        output out_last
    );
endinterface

// File: rtl/psum_drain_collector.sv
// Partial-sum drain collector: captures the column psums leaving the top row
// of the PE grid, accumulates them with signed saturation over a group of
// passes, then streams the per-column results one word per transfer with an
// optional ReLU. The grid is stalled (psum_ready low) while draining.
// All outputs come straight from registers; the first output word is
// precomputed from the next-state bank so it is ready the cycle after the
// final accept.
module psum_drain_collector #(
    parameter int NUM_COLS     = 14,
    parameter int PSUM_WIDTH   = 32,
    parameter int COL_ID_WIDTH = 4,
    parameter int PASS_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PASS_WIDTH-1:0] cfg_num_passes,
    input  logic                  cfg_relu,
    psum_drain_collector_if.slave bus,
    output logic                  busy,
    output logic [PASS_WIDTH-1:0] pass_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [COL_ID_WIDTH-1:0] LAST_COL = COL_ID_WIDTH'(NUM_COLS - 1);
    localparam logic [COL_ID_WIDTH-1:0] COL_ZERO = {COL_ID_WIDTH{1'b0}};
    localparam logic [COL_ID_WIDTH-1:0] COL_ONE  = COL_ID_WIDTH'(1);
    localparam logic [PASS_WIDTH-1:0]   PASS_ZERO = {PASS_WIDTH{1'b0}};
    localparam logic [PASS_WIDTH-1:0]   PASS_ONE  = PASS_WIDTH'(1);
    localparam logic [PSUM_WIDTH-1:0]   DATA_ZERO = {PSUM_WIDTH{1'b0}};

    // Signed add widened by one bit, clamped to the representable range.
    function automatic logic [PSUM_WIDTH-1:0] sat_add(
        input logic [PSUM_WIDTH-1:0] a,
        input logic [PSUM_WIDTH-1:0] b
    );
        logic [PSUM_WIDTH:0] sum;
        sum = {a[PSUM_WIDTH-1], a} + {b[PSUM_WIDTH-1], b};
        if (sum[PSUM_WIDTH] != sum[PSUM_WIDTH-1]) begin
            if (sum[PSUM_WIDTH]) begin
                sat_add = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
            end else begin
                sat_add = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
            end
        end else begin
            sat_add = sum[PSUM_WIDTH-1:0];
        end
    endfunction

    // Optional clamp of negative results to zero on the way out.
    function automatic logic [PSUM_WIDTH-1:0] relu_fn(
        input logic [PSUM_WIDTH-1:0] v,
        input logic                  en
    );
        if (en && v[PSUM_WIDTH-1]) begin
            relu_fn = DATA_ZERO;
        end else begin
            relu_fn = v;
        end
    endfunction

    logic [1:0]              state_r,    state_nxt_s;
    logic [PSUM_WIDTH-1:0]   acc_r       [0:NUM_COLS-1];
    logic [PSUM_WIDTH-1:0]   acc_nxt_s   [0:NUM_COLS-1];
    logic [PASS_WIDTH-1:0]   passes_r,   passes_nxt_s;
    logic [PASS_WIDTH-1:0]   pass_cnt_r, pass_cnt_nxt_s;
    logic                    relu_r,     relu_nxt_s;
    logic [COL_ID_WIDTH-1:0] col_r,      col_nxt_s;
    logic                    out_valid_r, out_valid_nxt_s;
    logic [PSUM_WIDTH-1:0]   out_data_r,  out_data_nxt_s;
    logic                    out_last_r,  out_last_nxt_s;
    logic                    psum_ready_r;
    logic                    busy_r;
    logic                    accept_s;
    logic                    drain_start_s;

    assign accept_s = bus.psum_valid & psum_ready_r;

    // Next-state, accumulation and drain-pointer logic.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        passes_nxt_s    = passes_r;
        relu_nxt_s      = relu_r;
        pass_cnt_nxt_s  = pass_cnt_r;
        col_nxt_s       = col_r;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        out_last_nxt_s  = out_last_r;
        drain_start_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    // First pass of a group overwrites the bank and latches config.
                    passes_nxt_s   = (cfg_num_passes == PASS_ZERO) ? PASS_ONE : cfg_num_passes;
                    relu_nxt_s     = cfg_relu;
                    pass_cnt_nxt_s = PASS_ONE;
                    for (int i = 0; i < NUM_COLS; i++) begin
                        acc_nxt_s[i] = bus.psum_in[i];
                    end
                    if (passes_nxt_s == PASS_ONE) begin
                        drain_start_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    pass_cnt_nxt_s = pass_cnt_r + PASS_ONE;
                    for (int i = 0; i < NUM_COLS; i++) begin
                        acc_nxt_s[i] = sat_add(acc_r[i], bus.psum_in[i]);
                    end
                    if (pass_cnt_nxt_s == passes_r) begin
                        drain_start_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (out_valid_r && bus.out_ready) begin
                    if (col_r == LAST_COL) begin
                        // Last word taken: close the group and reopen the grid.
                        state_nxt_s     = ST_IDLE;
                        pass_cnt_nxt_s  = PASS_ZERO;
                        col_nxt_s       = COL_ZERO;
                        out_valid_nxt_s = 1'b0;
                        out_data_nxt_s  = DATA_ZERO;
                        out_last_nxt_s  = 1'b0;
                    end else begin
                        col_nxt_s      = col_r + COL_ONE;
                        out_data_nxt_s = relu_fn(acc_r[col_nxt_s], relu_r);
                        out_last_nxt_s = (col_nxt_s == LAST_COL);
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                pass_cnt_nxt_s  = PASS_ZERO;
                col_nxt_s       = COL_ZERO;
                out_valid_nxt_s = 1'b0;
                out_data_nxt_s  = DATA_ZERO;
                out_last_nxt_s  = 1'b0;
            end
        endcase

        // Entering DRAIN presents column 0 of the freshly updated bank.
        if (drain_start_s) begin
            state_nxt_s     = ST_DRAIN;
            col_nxt_s       = COL_ZERO;
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = relu_fn(acc_nxt_s[0], relu_nxt_s);
            out_last_nxt_s  = (LAST_COL == COL_ZERO);
        end else begin
            drain_start_s = 1'b0;
        end
    end

    // State, bank and registered output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            passes_r     <= PASS_ONE;
            pass_cnt_r   <= PASS_ZERO;
            relu_r       <= 1'b0;
            col_r        <= COL_ZERO;
            out_valid_r  <= 1'b0;
            out_data_r   <= DATA_ZERO;
            out_last_r   <= 1'b0;
            psum_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                acc_r[i] <= DATA_ZERO;
            end
        end else begin
            state_r      <= state_nxt_s;
            passes_r     <= passes_nxt_s;
            pass_cnt_r   <= pass_cnt_nxt_s;
            relu_r       <= relu_nxt_s;
            col_r        <= col_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_data_r   <= out_data_nxt_s;
            out_last_r   <= out_last_nxt_s;
            psum_ready_r <= (state_nxt_s != ST_DRAIN);
            busy_r       <= (state_nxt_s != ST_IDLE);
            for (int i = 0; i < NUM_COLS; i++) begin
                acc_r[i] <= acc_nxt_s[i];
            end
        end
    end

    assign bus.psum_ready = psum_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_col    = col_r;
    assign bus.out_last   = out_last_r;
    assign busy           = busy_r;
    assign pass_cnt       = pass_cnt_r;

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed self-checking bench for psum_drain_collector. Inputs are driven
// and outputs sampled 1 ns after each rising edge.
module tb_psum_drain_collector;

    localparam int NC = 14;

    logic       clk;
    logic       rst;
    logic [3:0] cfg_num_passes;
    logic       cfg_relu;
    logic       busy;
    logic [3:0] pass_cnt;

    int n_cmp;
    int n_err;

    logic [31:0] exp_q [0:NC-1];

    psum_drain_collector_if #(.NUM_COLS(NC), .PSUM_WIDTH(32), .COL_ID_WIDTH(4)) bus_if ();

    psum_drain_collector #(
        .NUM_COLS(NC), .PSUM_WIDTH(32), .COL_ID_WIDTH(4), .PASS_WIDTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_num_passes (cfg_num_passes),
        .cfg_relu       (cfg_relu),
        .bus            (bus_if),
        .busy           (busy),
        .pass_cnt       (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec_lin(input int mul, input int add);
        for (int i = 0; i < NC; i++) begin
            bus_if.psum_in[i] = 32'(mul * i + add);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ovalid"}, {31'd0, bus_if.out_valid}, 32'd0);
        check({tag, "_pready"}, {31'd0, bus_if.psum_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_pcnt"}, {28'd0, pass_cnt}, 32'd0);
    endtask

    // Called in the first drain cycle; walks all 14 words against exp_q.
    // stall_mode 0: out_ready always 1, psum_valid low.
    // stall_mode 1: out_ready 1,0,0 repeating, psum_valid high with junk data.
    task automatic run_drain(input string tag, input int stall_mode);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < NC && cyc < 200) begin
            if (stall_mode == 0) begin
                bus_if.out_ready  = 1'b1;
                bus_if.psum_valid = 1'b0;
            end else begin
                bus_if.out_ready  = ((cyc % 3) == 0);
                bus_if.psum_valid = 1'b1;
                for (int i = 0; i < NC; i++) bus_if.psum_in[i] = 32'hDEAD0000 + 32'(i + cyc);
            end
            check({tag, "_ovalid"}, {31'd0, bus_if.out_valid}, 32'd1);
            check({tag, "_col"}, {28'd0, bus_if.out_col}, 32'(k));
            check({tag, "_data"}, bus_if.out_data, exp_q[k]);
            check({tag, "_last"}, {31'd0, bus_if.out_last}, (k == NC - 1) ? 32'd1 : 32'd0);
            check({tag, "_pready"}, {31'd0, bus_if.psum_ready}, 32'd0);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (bus_if.out_ready) k++;
            tick();
            cyc++;
        end
        bus_if.psum_valid = 1'b0;
        bus_if.out_ready  = 1'b1;
        check({tag, "_words"}, 32'(k), 32'(NC));
        check_idle({tag, "_end"});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        cfg_num_passes = 4'd1;
        cfg_relu = 1'b0;
        bus_if.psum_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        set_vec_lin(0, 0);
        tick();
        tick();

        // Reset values
        check_idle("rst");
        check("rst_odata", bus_if.out_data, 32'd0);
        check("rst_ocol", {28'd0, bus_if.out_col}, 32'd0);
        check("rst_olast", {31'd0, bus_if.out_last}, 32'd0);
        rst = 1'b1;
        tick();
        check_idle("rst_rel");

        // Single pass, no ReLU: i*100-500
        cfg_num_passes = 4'd1;
        cfg_relu = 1'b0;
        set_vec_lin(100, -500);
        bus_if.psum_valid = 1'b1;
        tick();
        for (int i = 0; i < NC; i++) exp_q[i] = 32'(i * 100 - 500);
        check("p1_pcnt", {28'd0, pass_cnt}, 32'd1);
        run_drain("p1", 0);

        // Three passes with ReLU: -10 + 3 + 4 = -3 -> 0; cfg changes ignored
        cfg_num_passes = 4'd3;
        cfg_relu = 1'b1;
        set_vec_lin(0, -10);
        bus_if.psum_valid = 1'b1;
        tick();
        check("p3_pcnt1", {28'd0, pass_cnt}, 32'd1);
        check("p3_busy", {31'd0, busy}, 32'd1);
        check("p3_pready1", {31'd0, bus_if.psum_ready}, 32'd1);
        cfg_relu = 1'b0;
        cfg_num_passes = 4'd1;
        set_vec_lin(0, 3);
        tick();
        check("p3_pcnt2", {28'd0, pass_cnt}, 32'd2);
        check("p3_ovalid2", {31'd0, bus_if.out_valid}, 32'd0);
        set_vec_lin(0, 4);
        tick();
        check("p3_pcnt3", {28'd0, pass_cnt}, 32'd3);
        for (int i = 0; i < NC; i++) exp_q[i] = 32'd0;
        run_drain("p3", 0);

        // Saturation over two passes, drained with stalls and junk psum_valid
        cfg_num_passes = 4'd2;
        cfg_relu = 1'b0;
        set_vec_lin(1, 0);
        bus_if.psum_in[5] = 32'h7FFFFFF0;
        bus_if.psum_in[6] = 32'h80000001;
        bus_if.psum_valid = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NC; i++) exp_q[i] = 32'(2 * i);
        exp_q[5] = 32'h7FFFFFFF;
        exp_q[6] = 32'h80000000;
        run_drain("sat", 1);

        // cfg_num_passes = 0 behaves as a single pass
        cfg_num_passes = 4'd0;
        set_vec_lin(1, 7);
        bus_if.psum_valid = 1'b1;
        tick();
        for (int i = 0; i < NC; i++) exp_q[i] = 32'(i + 7);
        run_drain("np0", 0);

        // Passes latched at 2 even if cfg moves to 5 mid-group
        cfg_num_passes = 4'd2;
        set_vec_lin(1, 0);
        bus_if.psum_valid = 1'b1;
        tick();
        cfg_num_passes = 4'd5;
        set_vec_lin(0, 1000);
        tick();
        for (int i = 0; i < NC; i++) exp_q[i] = 32'(i + 1000);
        run_drain("np2", 0);

        // Reset while presenting column 7 aborts the drain
        cfg_num_passes = 4'd1;
        set_vec_lin(3, 0);
        bus_if.psum_valid = 1'b1;
        tick();
        bus_if.psum_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("mrst_col7", {28'd0, bus_if.out_col}, 32'd7);
        check("mrst_data7", bus_if.out_data, 32'd21);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle("mrst");
        check("mrst_ocol", {28'd0, bus_if.out_col}, 32'd0);
        tick();
        check_idle("mrst_hold");

        // Fresh single-pass group with ReLU after the abort: i*5-30
        cfg_relu = 1'b1;
        set_vec_lin(5, -30);
        bus_if.psum_valid = 1'b1;
        tick();
        for (int i = 0; i < NC; i++) exp_q[i] = (i * 5 - 30 < 0) ? 32'd0 : 32'(i * 5 - 30);
        run_drain("post", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/psum_drain_collector.md
Name: psum_drain_collector

Overview:
- Downstream stage of the 12x14 PE grid. Captures the 14 column partial sums that leave the grid's top row after each processing pass.
- Accumulates them across a configurable number of passes in a local 14-entry bank, with signed saturation.
- Serializes the finished column results one word per transfer to the output buffer over a valid/ready handshake, with optional ReLU.
- Deasserts psum_ready to stall the grid controller while draining.

Parameters:
- NUM_COLS, 14, number of grid columns / bank entries.
- PSUM_WIDTH, 32, partial-sum width (signed two's complement).
- COL_ID_WIDTH, 4, width of out_col.
- PASS_WIDTH, 4, width of cfg_num_passes and pass_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous and active-low: sampled on the rising clk edge, and asserted when 0.
- cfg_num_passes  in  PASS_WIDTH  passes per group. Value 0 is treated as 1.
- cfg_relu  in  1  1 = clamp negative results to 0 on output.
- psum_valid  in  1  grid column psums are valid this cycle.
- psum_ready  out  1  collector can accept a psum vector.
- psum_in  in  PSUM_WIDTH x NUM_COLS (unpacked [0:NUM_COLS-1])  column psums from the grid top row.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  output buffer accepts the word.
- out_data  out  PSUM_WIDTH  result word.
- out_col  out  COL_ID_WIDTH  column index of out_data.
- out_last  out  1  high on the word for column NUM_COLS-1.
- busy  out  1  state != IDLE.
- pass_cnt  out  PASS_WIDTH  passes accepted in the current group.

Behaviour:
- Reset values (rst=0 at an edge):
  - State IDLE; all acc entries 0.
  - pass_cnt 0, psum_ready 1, out_valid 0, out_data 0, out_col 0, out_last 0, busy 0.
  - Reset mid-accumulate or mid-drain aborts the group. No partial output completes.
- Handshake: a psum vector is accepted iff psum_valid & psum_ready at the clock edge. When psum_ready=0, psum_valid is ignored; upstream must hold it.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - psum_ready=1.
  - On accept: latch passes = max(cfg_num_passes,1) and relu_q = cfg_relu; acc[i] <= psum_in[i] (overwrite, no add); pass_cnt <= 1.
  - Go to DRAIN if passes==1, else ACCUM.
- ACCUM:
  - psum_ready=1.
  - On accept: acc[i] <= sat(acc[i] + psum_in[i]); pass_cnt <= pass_cnt+1.
  - Go to DRAIN when the new pass_cnt == passes.
  - cfg_* changes during a group have no effect.
- Saturation rule:
  - Add at PSUM_WIDTH+1 bits.
  - Result > 2^31-1 gives 0x7FFFFFFF; result < -2^31 gives 0x80000000.
- DRAIN:
  - psum_ready=0. col pointer starts at 0.
  - out_valid=1. out_col=col. out_data = (relu_q && acc[col]<0) ? 0 : acc[col]. out_last = (col==NUM_COLS-1).
  - Output fields are stable while out_valid & !out_ready.
  - On each transfer (out_valid & out_ready): col++.
  - Transfer at col==NUM_COLS-1: go to IDLE, clear pass_cnt, set psum_ready=1 on the next cycle.
- Latency:
  - Final accept at edge T gives out_valid=1 with col 0 in cycle T+1.
  - With out_ready held at 1, 14 words in 14 consecutive cycles. psum_ready is back to 1 in cycle T+15.
- Simultaneous events: psum_valid during DRAIN is not accepted, including on the last drain cycle. Accepting resumes in the IDLE cycle that follows.
- No combinational path exists from psum_valid to psum_ready or from out_ready to out_valid.

Test Plan:
- passes=1, relu=0, psum_in[i]=i*100-500 → out words -500,-400,...,800 on out_col 0..13 in 14 consecutive cycles with out_ready=1. out_last only on col 13. psum_ready=0 for exactly those 14 cycles.
- passes=3, relu=1, three vectors with every psum_in[i]=-10, then 3, then 4 → all 14 outputs 0 (sum -3 clamped). pass_cnt reads 1,2,3 across the accepts.
- passes=2, psum_in[5]=0x7FFFFFF0 twice, psum_in[6]=0x80000001 twice → out_data col5=0x7FFFFFFF, col6=0x80000000.
- Drain with out_ready toggling 1,0,0,1,... → no word skipped or duplicated. out_data/out_col stable during stall. psum_valid=1 with new data during drain is not absorbed.
- cfg_num_passes=0 → behaves as 1 pass. Change cfg_num_passes from 2 to 5 after the first accept → group still drains after 2 passes.
- rst=0 for one cycle while out_col=7 in DRAIN → next cycle out_valid=0, psum_ready=1, busy=0. A new single-pass vector then drains from col 0.
